// File: rtl/mul_arb_pkg.sv
// -----------------------------------------------------------------------------
// mul_arb_pkg
// Shared constants, FSM state type and the round-robin winner search used by
// the mul_arbiter_5b block and its multiplier core.
//   MUL_W   : operand width of the multiplier core (5)
//   PROD_W  : product width of the multiplier core (10)
//   MAX_REQ : largest supported requester count (8)
// -----------------------------------------------------------------------------
package mul_arb_pkg;

  localparam int MUL_W   = 5;
  localparam int PROD_W  = 10;
  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RSP  = 1'b1
  } state_e;

  // Returns the first set bit of valid searching from ptr+1 upward, wrapping
  // modulo n. Returns ptr unchanged when no bit is set; callers only use the
  // result when at least one requester is valid.
  function automatic logic [2:0] rr_next(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = ptr;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if ((i <= n) && !found && valid[idx]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mul_core_5x5.sv
// -----------------------------------------------------------------------------
// mul_core_5x5
// Registered 5x5 unsigned multiplier. The product register loads a*b on the
// rising clock edge when en is high and otherwise holds its value.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears p to 0
//   en  : load enable
//   a,b : 5-bit unsigned operands
//   p   : 10-bit registered product
// -----------------------------------------------------------------------------
module mul_core_5x5
  import mul_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] p_d;
  logic [PROD_W-1:0] p_q;

  always_comb begin
    p_d = p_q;
    if (en) begin
      p_d = {{(PROD_W-MUL_W){1'b0}}, a} * {{(PROD_W-MUL_W){1'b0}}, b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/mul_arbiter_5b.sv
// -----------------------------------------------------------------------------
// mul_arbiter_5b
// Round-robin arbiter/sequencer sharing one registered 5x5 multiplier between
// N_REQ requesters. One requester is granted per cycle; its product returns on
// a single valid/ready response channel tagged with the requester index.
//
// Optional feature macro: MUL_ARB_STATS_EN adds the stat_ops output, a
// saturating 16-bit count of completed responses.
//
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester accept (one-hot or zero)
//   req_a/b    : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid  : product available
//   rsp_ready  : consumer accepts product
//   rsp_p      : 2*WIDTH-bit product
//   rsp_id     : index of the requester owning rsp_p
//   stat_ops   : completed-response count (MUL_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module mul_arbiter_5b
  import mul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 5,
  localparam int ID_W = $clog2(N_REQ)
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2*WIDTH-1:0]     rsp_p,
  output logic [ID_W-1:0]        rsp_id
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [15:0]            stat_ops
`endif
);

  if (WIDTH != MUL_W) begin : g_width_check
    $error("mul_arbiter_5b: WIDTH must equal the core width of 5");
  end
  if ((N_REQ < 2) || (N_REQ > MAX_REQ)) begin : g_nreq_check
    $error("mul_arbiter_5b: N_REQ must be in 2..8");
  end

  state_e          state_d, state_q;
  logic [ID_W-1:0] rr_ptr_d, rr_ptr_q;
  logic [ID_W-1:0] rsp_id_d, rsp_id_q;

  logic               can_issue;
  logic               any_valid;
  logic               grant;
  logic [MAX_REQ-1:0] valid_ext;
  logic [2:0]         ptr_ext;
  logic [2:0]         win_ext;
  logic [ID_W-1:0]    win;
  logic [MUL_W-1:0]   core_a;
  logic [MUL_W-1:0]   core_b;
  logic [PROD_W-1:0]  core_p;

  // Winner search runs on a fixed 8-wide view so one package function
  // serves every legal N_REQ.
  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = req_valid;
    ptr_ext                = '0;
    ptr_ext[ID_W-1:0]      = rr_ptr_q;
    win_ext                = rr_next(valid_ext, ptr_ext, N_REQ);
    win                    = win_ext[ID_W-1:0];
  end

  // A slot is free when idle, or when the pending response retires this cycle.
  // Reset is folded in so req_ready stays low while rst is held.
  assign can_issue = (state_q == IDLE) || rsp_ready;
  assign any_valid = |req_valid;
  assign grant     = can_issue && any_valid && !rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant && (win == ID_W'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  assign core_a = req_a[win*WIDTH +: WIDTH];
  assign core_b = req_b[win*WIDTH +: WIDTH];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    rsp_id_d = rsp_id_q;
    if (can_issue) begin
      state_d = any_valid ? RSP : IDLE;
    end
    if (grant) begin
      rr_ptr_d = win;
      rsp_id_d = win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= ID_W'(N_REQ-1);
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  mul_core_5x5 u_core (
    .clk (clk),
    .rst (rst),
    .en  (grant),
    .a   (core_a),
    .b   (core_b),
    .p   (core_p)
  );

  assign rsp_valid = (state_q == RSP);
  assign rsp_p     = core_p;
  assign rsp_id    = rsp_id_q;

`ifdef MUL_ARB_STATS_EN
  logic [15:0] stat_ops_d, stat_ops_q;

  always_comb begin
    stat_ops_d = stat_ops_q;
    if (rsp_valid && rsp_ready && (stat_ops_q != 16'hFFFF)) begin
      stat_ops_d = stat_ops_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops_q <= '0;
    end else begin
      stat_ops_q <= stat_ops_d;
    end
  end

  assign stat_ops = stat_ops_q;
`endif

endmodule

// File: tb/tb_mul_arbiter_5b.sv
`timescale 1ns/1ps
module tb_mul_arbiter_5b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [19:0] req_a = '0;
  logic [19:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [9:0]  rsp_p;
  logic [1:0]  rsp_id;
`ifdef MUL_ARB_STATS_EN
  logic [15:0] stat_ops;
`endif

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  mul_arbiter_5b #(.N_REQ(4), .WIDTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id)
`ifdef MUL_ARB_STATS_EN
    ,
    .stat_ops  (stat_ops)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input int i, input logic [4:0] a, input logic [4:0] b);
    req_a[i*5 +: 5] = a;
    req_b[i*5 +: 5] = b;
  endtask

  initial begin
    // Reset held
    cyc(); cyc();
    req_valid = 4'b1111;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_p",     32'(rsp_p), 0);
    chk("rst_rsp_id",    32'(rsp_id), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    cyc();
    rst = 1'b0;

    // Idle 10 cycles
    for (int k = 0; k < 10; k++) begin
      cyc();
      #1;
      chk("idle_rsp_valid", 32'(rsp_valid), 0);
      chk("idle_req_ready", 32'(req_ready), 0);
      chk("idle_rsp_p",     32'(rsp_p), 0);
    end

    // Single request: req 2, 31*31
    cyc();
    setop(2, 5'd31, 5'd31);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    chk("single_pre_valid", 32'(rsp_valid), 0);
    cyc();
    req_valid = '0;
    #1;
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_p", 32'(rsp_p), 961);
    chk("single_id", 32'(rsp_id), 2);
    chk("single_ready_drop", 32'(req_ready), 0);
    cyc();
    #1;
    chk("single_idle", 32'(rsp_valid), 0);

    // Zero operand from req 3 (leaves rr_ptr at 3)
    setop(3, 5'd0, 5'd17);
    req_valid = 4'b1000;
    #1;
    chk("zero_ready", 32'(req_ready), 32'h8);
    cyc();
    req_valid = '0;
    #1;
    chk("zero_p", 32'(rsp_p), 0);
    chk("zero_id", 32'(rsp_id), 3);
    chk("zero_valid", 32'(rsp_valid), 1);
    cyc();

    // All four valid, req i sends (i+1)*3: grants 0,1,2,3,0
    setop(0, 5'd1, 5'd3);
    setop(1, 5'd2, 5'd3);
    setop(2, 5'd3, 5'd3);
    setop(3, 5'd4, 5'd3);
    req_valid = 4'b1111;
    #1;
    chk("rr_ready_0", 32'(req_ready), 32'h1);
    cyc();
    #1;
    chk("rr_ready_1", 32'(req_ready), 32'h2);
    chk("rr_p_0", 32'(rsp_p), 3);
    chk("rr_id_0", 32'(rsp_id), 0);
    cyc();
    #1;
    chk("rr_ready_2", 32'(req_ready), 32'h4);
    chk("rr_p_1", 32'(rsp_p), 6);
    chk("rr_id_1", 32'(rsp_id), 1);
    cyc();
    #1;
    chk("rr_ready_3", 32'(req_ready), 32'h8);
    chk("rr_p_2", 32'(rsp_p), 9);
    chk("rr_id_2", 32'(rsp_id), 2);
    cyc();
    #1;
    chk("rr_ready_wrap", 32'(req_ready), 32'h1);
    chk("rr_p_3", 32'(rsp_p), 12);
    chk("rr_id_3", 32'(rsp_id), 3);
    chk("rr_valid_3", 32'(rsp_valid), 1);
    cyc();
    req_valid = '0;
    #1;
    chk("rr_p_wrap", 32'(rsp_p), 3);
    chk("rr_id_wrap", 32'(rsp_id), 0);
    cyc();
    #1;
    chk("rr_idle", 32'(rsp_valid), 0);

    // Back-pressure: req 2 (7*9) pending, req 1 (10*20) waits
    setop(2, 5'd7, 5'd9);
    setop(1, 5'd10, 5'd20);
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("bp_grant_idle", 32'(req_ready), 32'h4);
    cyc();
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_p_hold", 32'(rsp_p), 63);
      chk("bp_id_hold", 32'(rsp_id), 2);
      chk("bp_ready_low", 32'(req_ready), 0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h2);
    chk("bp_release_p", 32'(rsp_p), 63);
    cyc();
    req_valid = '0;
    #1;
    chk("bp_next_p", 32'(rsp_p), 200);
    chk("bp_next_id", 32'(rsp_id), 1);
    chk("bp_next_valid", 32'(rsp_valid), 1);
    cyc();
    #1;
    chk("bp_idle", 32'(rsp_valid), 0);

    // Reset mid-stall, then req 0 beats req 3
    setop(3, 5'd5, 5'd6);
    setop(0, 5'd2, 5'd2);
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    cyc();
    #1;
    chk("rs_stall_valid", 32'(rsp_valid), 1);
    chk("rs_stall_id", 32'(rsp_id), 3);
    chk("rs_stall_p", 32'(rsp_p), 30);
    req_valid = 4'b1001;
    rst = 1'b1;
    #1;
    chk("rs_async_valid", 32'(rsp_valid), 0);
    chk("rs_async_p", 32'(rsp_p), 0);
    chk("rs_async_id", 32'(rsp_id), 0);
    chk("rs_async_ready", 32'(req_ready), 0);
    cyc();
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("rs_first_ready", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    #1;
    chk("rs_first_p", 32'(rsp_p), 4);
    chk("rs_first_id", 32'(rsp_id), 0);
    cyc();
    #1;
    chk("rs_idle", 32'(rsp_valid), 0);

`ifdef MUL_ARB_STATS_EN
    // Counter: 20 responses, then drive it to saturation
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("stat_reset", 32'(stat_ops), 0);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) cyc();
    req_valid = '0;
    cyc();
    #1;
    chk("stat_20", 32'(stat_ops), 20);
    req_valid = 4'b0001;
    for (int k = 0; k < 65520; k++) cyc();
    req_valid = '0;
    cyc();
    #1;
    chk("stat_sat", 32'(stat_ops), 32'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
